// File: rtl/lbp_window_engine.sv
// 3x3 gray-pixel window with column shift-in and LBP code generation.
// Pixels arrive column-major; one 8-bit code is emitted per window position.
//
//   state | meaning
//   FILL  | collecting three columns after reset or init
//   SLIDE | collecting one new column to slide the window right
//   EMIT  | window complete; code registered on this edge
module lbp_window_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              busy
);

  typedef enum logic [1:0] {FILL, SLIDE, EMIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        row_idx, col_cnt;
  logic [DATA_W-1:0] stage [2];
  logic [DATA_W-1:0] win [3][3];  // [row][col]
  logic              accept, col_done, emit;
  logic [7:0]        code;

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (col_done && col_cnt == 2'd2) state_nxt = EMIT;
        SLIDE:   if (col_done) state_nxt = EMIT;
        EMIT:    state_nxt = SLIDE;
        default: state_nxt = FILL;
      endcase
    end
  end

  // init outranks both a pixel handshake and a pending emission
  always_comb begin
    pix_ready = (state != EMIT);
    emit      = (state == EMIT) && !init;
    accept    = pix_valid && pix_ready && !init;
    col_done  = accept && (row_idx == 2'd2);
  end

  always_comb begin
    code    = 8'd0;
    code[0] = win[0][0] >= win[1][1];
    code[1] = win[0][1] >= win[1][1];
    code[2] = win[0][2] >= win[1][1];
    code[3] = win[1][0] >= win[1][1];
    code[4] = win[1][2] >= win[1][1];
    code[5] = win[2][0] >= win[1][1];
    code[6] = win[2][1] >= win[1][1];
    code[7] = win[2][2] >= win[1][1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_idx   <= 2'd0;
      col_cnt   <= 2'd0;
      stage[0]  <= '0;
      stage[1]  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      lbp_data  <= 8'd0;
      lbp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      lbp_valid <= emit;
      if (init) begin
        row_idx <= 2'd0;
        col_cnt <= 2'd0;
        busy    <= 1'b0;
      end else begin
        if (accept) begin
          busy <= 1'b1;
          if (row_idx == 2'd2) begin
            for (int r = 0; r < 3; r++) begin
              win[r][0] <= win[r][1];
              win[r][1] <= win[r][2];
            end
            win[0][2] <= stage[0];
            win[1][2] <= stage[1];
            win[2][2] <= pix_data;
            row_idx   <= 2'd0;
            if (state == FILL)
              col_cnt <= (col_cnt == 2'd2) ? 2'd0 : col_cnt + 2'd1;
          end else begin
            stage[row_idx[0]] <= pix_data;
            row_idx           <= row_idx + 2'd1;
          end
        end
        if (emit) begin
          lbp_data <= code;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule
